dbg_burst_master: RTL and testbench
===================================

# dbg_burst_master

Bus-side burst sequencer for the debug unit: accepts one read or write burst command at a time and drives the shared system bus as a single master. It handles request/grant, the begin-transaction address phase, data phase with busy back-pressure, and termination by end-transaction, error or timeout. It sits between the JTAG debug command logic and the bus arbiter, on the system-clock side; all bus outputs are zero when idle so they can be OR-combined onto the bus.

## Interface
- TIMEOUT_CYCLES, 1024: system-clock cycles without bus progress before a transaction is aborted.
- sb_clock_i  in  1  system clock; only clock.
- sb_reset_i  in  1  synchronous, active-high reset.
- cmd_valid_i / cmd_ready_o  in/out  1  command handshake; accepted when both high at a clock edge.
- cmd_write_i  in  1  1 = write burst, 0 = read burst.
- cmd_addr_i  in  32  word address of first beat.
- cmd_count_i  in  9  word count, legal 1..256.
- wdata_i  in  32  write word; wdata_valid_i in 1; wdata_ready_o out 1.
- rdata_o  out  32  read word; rdata_valid_o out 1 (no back-pressure, consumer must accept).
- done_o  out  1  one-cycle pulse at end of every accepted command.
- status_o  out  2  valid with done_o: 00 ok, 01 bus error, 10 timeout, 11 protocol (bad count or short read burst).
- sb_request_o out 1; sb_grant_i in 1.
- sb_begin_transaction_o, sb_end_transaction_o, sb_data_valid_o, sb_read_n_write_o  out  1.
- sb_address_data_o out 32; sb_byte_enables_o out 4; sb_burst_size_o out 8.
- sb_address_data_i in 32; sb_end_transaction_i, sb_data_valid_i, sb_busy_i, sb_error_i  in  1.

## Operation
- IDLE: cmd_ready_o=1. On accept latch cmd fields. If count is 0 or >256: next cycle done_o=1, status 11, no bus activity. Else -> REQ.
- REQ: sb_request_o=1 until return to IDLE. Waits indefinitely for sb_grant_i; no timeout here. Grant seen -> BEGIN.
- BEGIN (exactly 1 cycle): sb_begin_transaction_o=1, sb_address_data_o=addr, sb_byte_enables_o=4'hF, sb_burst_size_o=count-1, sb_read_n_write_o=~write. -> RDATA or WDATA.
- RDATA: each cycle with sb_data_valid_i=1 and remaining>0: rdata_o=sb_address_data_i, rdata_valid_o=1 next cycle, remaining-1. Beats beyond count are dropped. sb_end_transaction_i -> DONE with status 00 if remaining=0, else 11.
- WDATA: wdata_ready_o=1 when no word is held on the bus. Held word drives sb_data_valid_o=1 and sb_address_data_o=word; a beat completes at an edge where sb_data_valid_o=1 and sb_busy_i=0; while busy the word is held unchanged. After last beat -> WEND.
- WEND (1 cycle): sb_end_transaction_o=1 -> DONE status 00.
- sb_error_i=1 in BEGIN, RDATA, WDATA or WEND: all bus outputs 0 from next cycle, DONE status 01; master does not drive end-transaction.
- Timeout: counter cleared at BEGIN and on every beat; reaching TIMEOUT_CYCLES in RDATA/WDATA -> 1-cycle sb_end_transaction_o, then DONE status 10.
- DONE (1 cycle): done_o=1, request released -> IDLE.
- Error has priority over timeout and over a simultaneous data beat; sb_end_transaction_i simultaneous with final data beat counts the beat.

## Timing
- Reset: every output 0 except cmd_ready_o=1 one cycle after reset release; state IDLE, counters 0. Reset mid-burst drops all bus outputs next cycle; no done_o.
- All outputs registered. Command accept to sb_request_o: 1 cycle. Grant to begin: 1 cycle.
- Read beat to rdata_valid_o: 1 cycle. Minimum write burst of N beats with no busy: N+1 cycles after BEGIN plus WEND.
- sb_* data/address outputs are 0 in every cycle where the block is not driving them.

## Structure
- Package dbg_bus_pkg: state enum (IDLE, REQ, BEGIN, RDATA, WDATA, WEND, DONE), status codes, BURST_MAX=256.
- Sub-module dbg_bus_timeout: loadable/clearable down-counter with expiry pulse, parameterised by TIMEOUT_CYCLES.

## Test plan
- Read 1 word @0x1000; slave returns 0xDEADBEEF 20 cycles after grant, end 3 cycles later -> rdata 0xDEADBEEF once, burst_size 0, done status 00.
- Write 4 words 0x1..0x4 @0x2000, slave busy 5 cycles on beat 2 -> beats appear in order, beat 2 held stable, end_transaction after beat 4, status 00.
- Read 4 words, slave ends after 2 beats -> 2 rdata_valid pulses, status 11.
- Write 2 words, slave error during busy -> outputs 0 next cycle, no end_transaction from master, status 01.
- Read 1 word, slave silent, TIMEOUT_CYCLES=16 -> end_transaction pulse at cycle 16 after BEGIN, status 10.
- cmd_count 0 and 257 -> no request, done status 11; reset asserted mid-write -> all bus outputs 0 next cycle.

Source files
------------

// File: rtl/dbg_bus_pkg.sv
// Shared types and constants for the debug-unit bus burst master.
package dbg_bus_pkg;

    localparam int DATA_W    = 32;
    localparam int COUNT_W   = 9;
    localparam int BURST_MAX = 256;

    localparam logic [3:0] BYTE_EN_ALL = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_BEGIN,
        S_RDATA,
        S_WDATA,
        S_WEND,
        S_DONE
    } bus_state_t;

    typedef enum logic [1:0] {
        STATUS_OK       = 2'b00,
        STATUS_BUS_ERR  = 2'b01,
        STATUS_TIMEOUT  = 2'b10,
        STATUS_PROTOCOL = 2'b11
    } status_t;

    // A burst is legal for 1..BURST_MAX words; anything else is refused
    // without touching the bus.
    function automatic logic count_legal(input logic [COUNT_W-1:0] count);
        return (count != '0) && (count <= COUNT_W'(BURST_MAX));
    endfunction

endpackage

// File: rtl/dbg_bus_timeout.sv
// Progress watchdog: a down-counter reloaded whenever the bus makes
// progress; flags expiry in the cycle it would reach zero.
module dbg_bus_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic srst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_reg;

    // Reload on progress, otherwise count down while the watchdog is armed.
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= CNT_INIT;
        end else if (en && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    // The last counting cycle; the owner acts on it at the next edge.
    assign expired = en && (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/dbg_burst_master.sv
// Single-master burst sequencer between the debug command logic and the
// system bus. All bus outputs are registered and forced to zero whenever
// this block is not actively driving them, so they can be OR-combined.
module dbg_burst_master
    import dbg_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                sb_clock_i,
    input  logic                sb_reset_i,

    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_write_i,
    input  logic [DATA_W-1:0]   cmd_addr_i,
    input  logic [COUNT_W-1:0]  cmd_count_i,

    input  logic [DATA_W-1:0]   wdata_i,
    input  logic                wdata_valid_i,
    output logic                wdata_ready_o,

    output logic [DATA_W-1:0]   rdata_o,
    output logic                rdata_valid_o,

    output logic                done_o,
    output logic [1:0]          status_o,

    output logic                sb_request_o,
    input  logic                sb_grant_i,

    output logic                sb_begin_transaction_o,
    output logic                sb_end_transaction_o,
    output logic                sb_data_valid_o,
    output logic                sb_read_n_write_o,
    output logic [DATA_W-1:0]   sb_address_data_o,
    output logic [3:0]          sb_byte_enables_o,
    output logic [7:0]          sb_burst_size_o,

    input  logic [DATA_W-1:0]   sb_address_data_i,
    input  logic                sb_end_transaction_i,
    input  logic                sb_data_valid_i,
    input  logic                sb_busy_i,
    input  logic                sb_error_i
);

    bus_state_t         state_reg;
    logic               write_reg;
    logic [DATA_W-1:0]  addr_reg;
    logic [COUNT_W-1:0] remaining_reg;     // beats still to complete on the bus
    logic [COUNT_W-1:0] accept_left_reg;   // write words still to take from the source
    logic               stg_valid_reg;     // write word waiting behind the one on the bus
    logic [DATA_W-1:0]  stg_data_reg;
    status_t            status_reg;        // status to report after the WEND cycle

    logic               rd_beat;
    logic               wr_beat;
    logic               wr_accept;
    logic               wr_bus_free;
    logic               stg_valid_next;
    logic [COUNT_W-1:0] accept_left_next;
    logic [COUNT_W-1:0] rem_after_rd;
    logic               tmo_load;
    logic               tmo_en;
    logic               tmo_expired;

    // Beat detection, write-side flow control and watchdog control.
    always_comb begin
        rd_beat     = (state_reg == S_RDATA) && sb_data_valid_i && (remaining_reg != '0);
        wr_beat     = (state_reg == S_WDATA) && sb_data_valid_o && !sb_busy_i;
        wr_accept   = (state_reg == S_WDATA) && wdata_valid_i && wdata_ready_o;
        // The bus slot can take a new word if it is empty or its beat completes now.
        wr_bus_free = !sb_data_valid_o || !sb_busy_i;
        // A freed slot always drains the staging word, so staging only fills
        // while the bus word is stalled.
        stg_valid_next   = wr_bus_free ? 1'b0 : (stg_valid_reg || wr_accept);
        accept_left_next = accept_left_reg - {{(COUNT_W-1){1'b0}}, wr_accept};
        rem_after_rd     = remaining_reg - {{(COUNT_W-1){1'b0}}, rd_beat};
        tmo_load = ((state_reg == S_REQ) && sb_grant_i) || rd_beat || wr_beat;
        tmo_en   = (state_reg == S_BEGIN) || (state_reg == S_RDATA) || (state_reg == S_WDATA);
    end

    dbg_bus_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (sb_clock_i),
        .srst    (sb_reset_i),
        .load    (tmo_load),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    // Burst sequencer with fully registered outputs; pulses and bus fields
    // default to zero every cycle and are re-asserted only where driven.
    always_ff @(posedge sb_clock_i) begin
        if (sb_reset_i) begin
            state_reg              <= S_IDLE;
            write_reg              <= 1'b0;
            addr_reg               <= '0;
            remaining_reg          <= '0;
            accept_left_reg        <= '0;
            stg_valid_reg          <= 1'b0;
            stg_data_reg           <= '0;
            status_reg             <= STATUS_OK;
            cmd_ready_o            <= 1'b1;
            wdata_ready_o          <= 1'b0;
            rdata_o                <= '0;
            rdata_valid_o          <= 1'b0;
            done_o                 <= 1'b0;
            status_o               <= 2'b00;
            sb_request_o           <= 1'b0;
            sb_begin_transaction_o <= 1'b0;
            sb_end_transaction_o   <= 1'b0;
            sb_data_valid_o        <= 1'b0;
            sb_read_n_write_o      <= 1'b0;
            sb_address_data_o      <= '0;
            sb_byte_enables_o      <= 4'h0;
            sb_burst_size_o        <= 8'h00;
        end else begin
            rdata_o                <= '0;
            rdata_valid_o          <= 1'b0;
            done_o                 <= 1'b0;
            status_o               <= 2'b00;
            wdata_ready_o          <= 1'b0;
            sb_begin_transaction_o <= 1'b0;
            sb_end_transaction_o   <= 1'b0;
            sb_data_valid_o        <= 1'b0;
            sb_read_n_write_o      <= 1'b0;
            sb_address_data_o      <= '0;
            sb_byte_enables_o      <= 4'h0;
            sb_burst_size_o        <= 8'h00;

            case (state_reg)
                S_IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        cmd_ready_o     <= 1'b0;
                        write_reg       <= cmd_write_i;
                        addr_reg        <= cmd_addr_i;
                        remaining_reg   <= cmd_count_i;
                        accept_left_reg <= cmd_count_i;
                        stg_valid_reg   <= 1'b0;
                        status_reg      <= STATUS_OK;
                        if (count_legal(cmd_count_i)) begin
                            sb_request_o <= 1'b1;
                            state_reg    <= S_REQ;
                        end else begin
                            done_o    <= 1'b1;
                            status_o  <= STATUS_PROTOCOL;
                            state_reg <= S_DONE;
                        end
                    end
                end

                S_REQ: begin
                    if (sb_grant_i) begin
                        sb_begin_transaction_o <= 1'b1;
                        sb_address_data_o      <= addr_reg;
                        sb_byte_enables_o      <= BYTE_EN_ALL;
                        sb_burst_size_o        <= 8'(remaining_reg - COUNT_W'(1));
                        sb_read_n_write_o      <= ~write_reg;
                        state_reg              <= S_BEGIN;
                    end
                end

                S_BEGIN: begin
                    if (sb_error_i) begin
                        sb_request_o <= 1'b0;
                        done_o       <= 1'b1;
                        status_o     <= STATUS_BUS_ERR;
                        state_reg    <= S_DONE;
                    end else if (write_reg) begin
                        wdata_ready_o <= (accept_left_reg != '0);
                        state_reg     <= S_WDATA;
                    end else begin
                        state_reg <= S_RDATA;
                    end
                end

                S_RDATA: begin
                    if (sb_error_i) begin
                        sb_request_o <= 1'b0;
                        done_o       <= 1'b1;
                        status_o     <= STATUS_BUS_ERR;
                        state_reg    <= S_DONE;
                    end else begin
                        if (rd_beat) begin
                            rdata_o       <= sb_address_data_i;
                            rdata_valid_o <= 1'b1;
                            remaining_reg <= rem_after_rd;
                        end
                        if (sb_end_transaction_i) begin
                            sb_request_o <= 1'b0;
                            done_o       <= 1'b1;
                            status_o     <= (rem_after_rd == '0) ? STATUS_OK : STATUS_PROTOCOL;
                            state_reg    <= S_DONE;
                        end else if (tmo_expired && !rd_beat) begin
                            sb_end_transaction_o <= 1'b1;
                            status_reg           <= STATUS_TIMEOUT;
                            state_reg            <= S_WEND;
                        end
                    end
                end

                S_WDATA: begin
                    if (sb_error_i) begin
                        stg_valid_reg <= 1'b0;
                        sb_request_o  <= 1'b0;
                        done_o        <= 1'b1;
                        status_o      <= STATUS_BUS_ERR;
                        state_reg     <= S_DONE;
                    end else if (wr_beat && (remaining_reg == COUNT_W'(1))) begin
                        remaining_reg        <= '0;
                        sb_end_transaction_o <= 1'b1;
                        status_reg           <= STATUS_OK;
                        state_reg            <= S_WEND;
                    end else if (tmo_expired && !wr_beat) begin
                        stg_valid_reg        <= 1'b0;
                        sb_end_transaction_o <= 1'b1;
                        status_reg           <= STATUS_TIMEOUT;
                        state_reg            <= S_WEND;
                    end else begin
                        if (wr_beat) begin
                            remaining_reg <= remaining_reg - COUNT_W'(1);
                        end
                        accept_left_reg <= accept_left_next;
                        if (wr_bus_free) begin
                            if (stg_valid_reg) begin
                                sb_data_valid_o   <= 1'b1;
                                sb_address_data_o <= stg_data_reg;
                            end else if (wr_accept) begin
                                sb_data_valid_o   <= 1'b1;
                                sb_address_data_o <= wdata_i;
                            end
                        end else begin
                            // Stalled by busy: keep the word exactly as presented.
                            sb_data_valid_o   <= 1'b1;
                            sb_address_data_o <= sb_address_data_o;
                            if (wr_accept) begin
                                stg_data_reg <= wdata_i;
                            end
                        end
                        stg_valid_reg <= stg_valid_next;
                        wdata_ready_o <= !stg_valid_next && (accept_left_next != '0);
                    end
                end

                S_WEND: begin
                    sb_request_o <= 1'b0;
                    done_o       <= 1'b1;
                    status_o     <= sb_error_i ? STATUS_BUS_ERR : status_reg;
                    state_reg    <= S_DONE;
                end

                S_DONE: begin
                    sb_request_o <= 1'b0;
                    cmd_ready_o  <= 1'b1;
                    state_reg    <= S_IDLE;
                end

                default: begin
                    sb_request_o <= 1'b0;
                    cmd_ready_o  <= 1'b1;
                    state_reg    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_burst_master.sv
// Directed bench for dbg_burst_master: read, write with busy, short read,
// bus error, timeout, illegal counts and reset mid-burst.
module tb_dbg_burst_master;

    logic        clk = 1'b0;
    logic        srst = 1'b1;

    logic        cmd_valid = 1'b0;
    logic        cmd_valid_t = 1'b0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [8:0]  cmd_count = '0;
    logic [31:0] wdata = '0;
    logic        wdata_valid = 1'b0;
    logic        grant = 1'b0;
    logic        grant_t = 1'b0;
    logic [31:0] sb_ad_in = '0;
    logic        sb_end_in = 1'b0;
    logic        sb_dv_in = 1'b0;
    logic        sb_busy = 1'b0;
    logic        sb_err = 1'b0;

    logic        cmd_ready, wdata_ready, rdata_valid, done, req, beg, endo, dvo, rnw;
    logic [31:0] rdata, ado;
    logic [1:0]  status;
    logic [3:0]  be;
    logic [7:0]  bsz;

    logic        cmd_ready_t, wdata_ready_t, rdata_valid_t, done_t, req_t, beg_t, endo_t, dvo_t, rnw_t;
    logic [31:0] rdata_t, ado_t;
    logic [1:0]  status_t_o;
    logic [3:0]  be_t;
    logic [7:0]  bsz_t;

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [31:0] rd_q[$];
    logic [31:0] wr_q[$];
    int          end_beats_q[$];
    int          end_cnt = 0;

    always #5 clk = ~clk;

    dbg_burst_master #(.TIMEOUT_CYCLES(1024)) dut (
        .sb_clock_i(clk), .sb_reset_i(srst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_count_i(cmd_count),
        .wdata_i(wdata), .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready),
        .rdata_o(rdata), .rdata_valid_o(rdata_valid),
        .done_o(done), .status_o(status),
        .sb_request_o(req), .sb_grant_i(grant),
        .sb_begin_transaction_o(beg), .sb_end_transaction_o(endo),
        .sb_data_valid_o(dvo), .sb_read_n_write_o(rnw),
        .sb_address_data_o(ado), .sb_byte_enables_o(be), .sb_burst_size_o(bsz),
        .sb_address_data_i(sb_ad_in), .sb_end_transaction_i(sb_end_in),
        .sb_data_valid_i(sb_dv_in), .sb_busy_i(sb_busy), .sb_error_i(sb_err)
    );

    dbg_burst_master #(.TIMEOUT_CYCLES(16)) dut_tmo (
        .sb_clock_i(clk), .sb_reset_i(srst),
        .cmd_valid_i(cmd_valid_t), .cmd_ready_o(cmd_ready_t), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_count_i(cmd_count),
        .wdata_i(wdata), .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready_t),
        .rdata_o(rdata_t), .rdata_valid_o(rdata_valid_t),
        .done_o(done_t), .status_o(status_t_o),
        .sb_request_o(req_t), .sb_grant_i(grant_t),
        .sb_begin_transaction_o(beg_t), .sb_end_transaction_o(endo_t),
        .sb_data_valid_o(dvo_t), .sb_read_n_write_o(rnw_t),
        .sb_address_data_o(ado_t), .sb_byte_enables_o(be_t), .sb_burst_size_o(bsz_t),
        .sb_address_data_i(sb_ad_in), .sb_end_transaction_i(sb_end_in),
        .sb_data_valid_i(sb_dv_in), .sb_busy_i(sb_busy), .sb_error_i(sb_err)
    );

    // Record read words, completed write beats and master end-transaction pulses.
    always @(posedge clk) begin
        if (rdata_valid) rd_q.push_back(rdata);
        if (dvo && !sb_busy) wr_q.push_back(ado);
        if (endo) begin
            end_cnt++;
            end_beats_q.push_back(wr_q.size());
        end
    end

    // Hard stop in case a directed step never completes.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [8:0] cnt);
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_count = cnt;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] wwords [4];
        int rd_base, wr_base, end_base, idx, busy_left, hold_bad, last_end;
        logic hs, prev_hold, got_done;
        logic [31:0] prev_word;

        wwords[0] = 32'h1; wwords[1] = 32'h2; wwords[2] = 32'h3; wwords[3] = 32'h4;

        // ---------------- reset ----------------
        repeat (3) tick();
        srst = 1'b0;
        tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        check("rst_request", 32'(req), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_bus_ad", ado, 32'h0);
        check("rst_bus_dv", 32'(dvo), 32'h0);
        $display("txn reset released");

        // ---------------- read 1 word ----------------
        rd_base = rd_q.size(); end_base = end_cnt;
        issue(1'b0, 32'h1000, 9'd1);
        check("rd1_request", 32'(req), 32'h1);
        grant = 1'b1;
        tick();
        grant = 1'b0;
        check("rd1_begin", 32'(beg), 32'h1);
        check("rd1_addr", ado, 32'h1000);
        check("rd1_burst", 32'(bsz), 32'h0);
        check("rd1_rnw", 32'(rnw), 32'h1);
        check("rd1_be", 32'(be), 32'hF);
        repeat (19) tick();
        check("rd1_no_early_data", 32'(rdata_valid), 32'h0);
        sb_dv_in = 1'b1; sb_ad_in = 32'hDEADBEEF;
        tick();
        sb_dv_in = 1'b0; sb_ad_in = 32'h0;
        check("rd1_rvalid", 32'(rdata_valid), 32'h1);
        check("rd1_rdata", rdata, 32'hDEADBEEF);
        tick(); tick();
        sb_end_in = 1'b1;
        tick();
        sb_end_in = 1'b0;
        check("rd1_done", 32'(done), 32'h1);
        check("rd1_status", 32'(status), 32'h0);
        check("rd1_req_released", 32'(req), 32'h0);
        check("rd1_nwords", 32'(rd_q.size() - rd_base), 32'd1);
        check("rd1_no_master_end", 32'(end_cnt - end_base), 32'd0);
        tick();
        check("rd1_idle_ready", 32'(cmd_ready), 32'h1);
        $display("txn read1 addr=0x1000 status=%0d", status);

        // ---------------- write 4 words with busy on beat 2 ----------------
        wr_base = wr_q.size(); end_base = end_cnt;
        issue(1'b1, 32'h2000, 9'd4);
        grant = 1'b1;
        tick();
        grant = 1'b0;
        check("wr4_begin", 32'(beg), 32'h1);
        check("wr4_addr", ado, 32'h2000);
        check("wr4_burst", 32'(bsz), 32'h3);
        check("wr4_rnw", 32'(rnw), 32'h0);
        idx = 0; busy_left = 5; hold_bad = 0; got_done = 1'b0;
        wdata_valid = 1'b1; wdata = wwords[0];
        for (int cyc = 0; cyc < 60 && !got_done; cyc++) begin
            hs = wdata_valid && wdata_ready;
            prev_hold = dvo && sb_busy;
            prev_word = ado;
            tick();
            if (hs) idx++;
            if (idx < 4) begin
                wdata_valid = 1'b1; wdata = wwords[idx];
            end else begin
                wdata_valid = 1'b0; wdata = 32'h0;
            end
            if (prev_hold && (!dvo || ado != prev_word)) hold_bad++;
            if (dvo && ado == 32'h2 && busy_left > 0) begin
                sb_busy = 1'b1; busy_left--;
            end else begin
                sb_busy = 1'b0;
            end
            if (done) got_done = 1'b1;
        end
        sb_busy = 1'b0;
        check("wr4_done_seen", 32'(got_done), 32'h1);
        check("wr4_status", 32'(status), 32'h0);
        check("wr4_busy_used", 32'(busy_left), 32'd0);
        check("wr4_hold_stable", 32'(hold_bad), 32'd0);
        check("wr4_nbeats", 32'(wr_q.size() - wr_base), 32'd4);
        if (wr_q.size() - wr_base == 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("wr4_beat%0d", i), wr_q[wr_base + i], wwords[i]);
        end
        check("wr4_end_pulses", 32'(end_cnt - end_base), 32'd1);
        last_end = (end_beats_q.size() > 0) ? end_beats_q[end_beats_q.size() - 1] : 0;
        check("wr4_end_after_beat4", 32'(last_end - wr_base), 32'd4);
        tick();
        $display("txn write4 addr=0x2000 beats=%0d", wr_q.size() - wr_base);

        // ---------------- short read: 4 requested, 2 delivered ----------------
        rd_base = rd_q.size();
        issue(1'b0, 32'h3000, 9'd4);
        grant = 1'b1;
        tick();
        grant = 1'b0;
        check("rd4_burst", 32'(bsz), 32'h3);
        tick();
        sb_dv_in = 1'b1; sb_ad_in = 32'hA1;
        tick();
        sb_ad_in = 32'hA2;
        tick();
        sb_dv_in = 1'b0; sb_ad_in = 32'h0; sb_end_in = 1'b1;
        tick();
        sb_end_in = 1'b0;
        check("rd4_done", 32'(done), 32'h1);
        check("rd4_status", 32'(status), 32'h3);
        check("rd4_nwords", 32'(rd_q.size() - rd_base), 32'd2);
        if (rd_q.size() - rd_base == 2) begin
            check("rd4_word0", rd_q[rd_base], 32'hA1);
            check("rd4_word1", rd_q[rd_base + 1], 32'hA2);
        end
        tick();
        $display("txn shortread status=%0d words=%0d", status, rd_q.size() - rd_base);

        // ---------------- write with bus error during busy ----------------
        end_base = end_cnt;
        issue(1'b1, 32'h3100, 9'd2);
        grant = 1'b1;
        tick();
        grant = 1'b0;
        wdata_valid = 1'b1; wdata = 32'h11;
        tick();
        tick();
        wdata_valid = 1'b0; wdata = 32'h0; sb_busy = 1'b1;
        check("err_dv_on", 32'(dvo), 32'h1);
        check("err_word", ado, 32'h11);
        tick();
        check("err_word_held", ado, 32'h11);
        sb_err = 1'b1;
        tick();
        sb_err = 1'b0; sb_busy = 1'b0;
        check("err_dv_off", 32'(dvo), 32'h0);
        check("err_ad_zero", ado, 32'h0);
        check("err_req_off", 32'(req), 32'h0);
        check("err_no_end", 32'(endo), 32'h0);
        check("err_done", 32'(done), 32'h1);
        check("err_status", 32'(status), 32'h1);
        check("err_wready_off", 32'(wdata_ready), 32'h0);
        tick();
        check("err_idle_ready", 32'(cmd_ready), 32'h1);
        check("err_end_pulses", 32'(end_cnt - end_base), 32'd0);
        $display("txn write_error status=1 expected");

        // ---------------- timeout (watchdog of 16 cycles) ----------------
        cmd_write = 1'b0; cmd_addr = 32'h4000; cmd_count = 9'd1; cmd_valid_t = 1'b1;
        tick();
        cmd_valid_t = 1'b0;
        check("tmo_request", 32'(req_t), 32'h1);
        grant_t = 1'b1;
        tick();
        grant_t = 1'b0;
        check("tmo_begin", 32'(beg_t), 32'h1);
        repeat (15) tick();
        check("tmo_no_end_c15", 32'(endo_t), 32'h0);
        tick();
        check("tmo_end_c16", 32'(endo_t), 32'h1);
        tick();
        check("tmo_end_one_cycle", 32'(endo_t), 32'h0);
        check("tmo_done", 32'(done_t), 32'h1);
        check("tmo_status", 32'(status_t_o), 32'h2);
        tick();
        $display("txn timeout status=%0d", status_t_o);

        // ---------------- illegal counts ----------------
        issue(1'b0, 32'h5000, 9'd0);
        check("cnt0_no_req", 32'(req), 32'h0);
        check("cnt0_done", 32'(done), 32'h1);
        check("cnt0_status", 32'(status), 32'h3);
        tick();
        check("cnt0_idle_ready", 32'(cmd_ready), 32'h1);
        issue(1'b1, 32'h5000, 9'd257);
        check("cnt257_no_req", 32'(req), 32'h0);
        check("cnt257_done", 32'(done), 32'h1);
        check("cnt257_status", 32'(status), 32'h3);
        tick();
        $display("txn illegal_counts done");

        // ---------------- reset mid-write ----------------
        issue(1'b1, 32'h6000, 9'd4);
        grant = 1'b1;
        tick();
        grant = 1'b0;
        wdata_valid = 1'b1; wdata = 32'hAA;
        tick();
        tick();
        wdata_valid = 1'b0; wdata = 32'h0; sb_busy = 1'b1;
        check("mrst_dv_before", 32'(dvo), 32'h1);
        srst = 1'b1;
        tick();
        check("mrst_dv", 32'(dvo), 32'h0);
        check("mrst_ad", ado, 32'h0);
        check("mrst_req", 32'(req), 32'h0);
        check("mrst_done", 32'(done), 32'h0);
        check("mrst_cmd_ready", 32'(cmd_ready), 32'h1);
        srst = 1'b0; sb_busy = 1'b0;
        tick();
        check("mrst_no_done_after", 32'(done), 32'h0);
        $display("txn reset_mid_write");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
